// File: rtl/aes_decrypt_core.sv
// AES-128 iterative decryption core: 10-edge forward key walk, then
// 10 inverse rounds stepping the key schedule backwards.
module aes_decrypt_core (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid,
    output logic         AES_busy
);

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} fsm_t;

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] key;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 via a short addition chain.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a15  = gmul(a12, a3);
        a30  = gmul(a15, a15);
        a60  = gmul(a30, a30);
        a120 = gmul(a60, a60);
        a240 = gmul(a120, a120);
        a252 = gmul(a240, a12);
        return gmul(a252, a2);
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  sw_in, sw_out;
    logic [127:0] key_fwd, key_inv;
    logic [127:0] sr_sb, ark, mc;
    logic [7:0]   a0, a1, a2, a3;

    // One SubWord shared by both schedule directions.
    always_comb begin
        w0 = key[127:96];
        w1 = key[95:64];
        w2 = key[63:32];
        w3 = key[31:0];
        sw_in = (fsm == KEYEXP) ? w3 : (w3 ^ w2);
        sw_out = {sbox(sw_in[23:16]), sbox(sw_in[15:8]),
                  sbox(sw_in[7:0]), sbox(sw_in[31:24])}
               ^ {rcon((fsm == KEYEXP) ? cnt : cnt + 4'd1), 24'h0};
        key_fwd[127:96] = w0 ^ sw_out;
        key_fwd[95:64]  = w1 ^ key_fwd[127:96];
        key_fwd[63:32]  = w2 ^ key_fwd[95:64];
        key_fwd[31:0]   = w3 ^ key_fwd[63:32];
        key_inv = {w0 ^ sw_out, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    end

    always_comb begin
        sr_sb = '0;
        mc    = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int i = 0; i < 16; i++) begin
            sr_sb[127-8*i -: 8] =
                inv_sbox(st[127-8*((i%4) + 4*(((i/4) + 4 - (i%4)) % 4)) -: 8]);
        end
        ark = sr_sb ^ key_inv;
        for (int c = 0; c < 4; c++) begin
            a0 = ark[127-32*c -: 8];
            a1 = ark[119-32*c -: 8];
            a2 = ark[111-32*c -: 8];
            a3 = ark[103-32*c -: 8];
            mc[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                              ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            mc[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                              ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            mc[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                              ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            mc[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                              ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
    end

    // In ROUND the counter holds the round index r of the key being produced.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm                <= IDLE;
            cnt                <= 4'd0;
            st                 <= '0;
            key                <= '0;
            AES_data_out       <= '0;
            AES_data_out_valid <= 1'b0;
            AES_busy           <= 1'b0;
        end else begin
            AES_data_out_valid <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (AES_en) begin
                        st       <= AES_data_in;
                        key      <= AES_key_in;
                        cnt      <= 4'd1;
                        AES_busy <= 1'b1;
                        fsm      <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    key <= key_fwd;
                    if (cnt == 4'd10) begin
                        st  <= st ^ key_fwd;
                        cnt <= 4'd9;
                        fsm <= ROUND;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ROUND: begin
                    key <= key_inv;
                    if (cnt == 4'd0) begin
                        AES_data_out       <= ark;
                        AES_data_out_valid <= 1'b1;
                        AES_busy           <= 1'b0;
                        fsm                <= IDLE;
                    end else begin
                        st  <= mc;
                        cnt <= cnt - 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule
